// File: rtl/spell_mem_pkg.sv
// Shared definitions for the SPELL memory port.
// Holds the requester state encoding, the memory-space select values and the
// default address/data widths used by spell_mem_requester.
package spell_mem_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 8;
    localparam int unsigned DEF_DATA_WIDTH = 8;

    localparam logic MEM_SPACE_CODE = 1'b0;
    localparam logic MEM_SPACE_DATA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/spell_mem_requester.sv
// Initiator side of the SPELL memory port.
// Takes one read/write request at a time from the core, presents it to the
// responder on the mem_* lines, waits for mem_data_ready and returns a
// one-cycle response. Every access is bounded by a timeout.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           core request handshake
//   req_write, req_data_space     access kind and memory space
//   req_addr, req_wdata           access address and write data
//   rsp_valid                     one-cycle completion pulse
//   rsp_rdata, rsp_error          read data (0 for writes/timeouts), timeout flag
//   mem_select, mem_addr,         responder request lines, held stable while
//   mem_data_in, mem_type_data,   mem_select is high
//   mem_write
//   mem_data_out, mem_data_ready  responder read data and completion flag
module spell_mem_requester
    import spell_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_data_space,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,

    output logic                  mem_select,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_type_data,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic                  mem_data_ready
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_can_accept;

    // A responder still showing data_ready from an earlier access must not
    // let a new request in; otherwise the stale flag would complete it.
    assign w_can_accept = (r_state == ST_IDLE) && !mem_data_ready;

    // Reset is kept out of the flopped accept path and only gates the port.
    assign req_ready = w_can_accept && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            mem_select    <= 1'b0;
            mem_addr      <= '0;
            mem_data_in   <= '0;
            mem_type_data <= 1'b0;
            mem_write     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_error     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    rsp_valid <= 1'b0;
                    rsp_error <= 1'b0;
                    if (req_valid && w_can_accept) begin
                        mem_addr      <= req_addr;
                        mem_data_in   <= req_wdata;
                        mem_write     <= req_write;
                        mem_type_data <= req_data_space;
                        mem_select    <= 1'b1;
                        r_cnt         <= '0;
                        r_state       <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    if (mem_data_ready) begin
                        mem_select <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_error  <= 1'b0;
                        rsp_rdata  <= mem_write ? '0 : mem_data_out;
                        r_state    <= ST_RELEASE;
                    end else if (r_cnt == CNT_LAST) begin
                        mem_select <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_error  <= 1'b1;
                        rsp_rdata  <= '0;
                        r_state    <= ST_RELEASE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_RELEASE: begin
                    // Late or lingering data_ready is absorbed here and
                    // never turns into a response.
                    rsp_valid <= 1'b0;
                    rsp_error <= 1'b0;
                    if (!mem_data_ready) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    mem_select <= 1'b0;
                    rsp_valid  <= 1'b0;
                    rsp_error  <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spell_mem_requester.sv
// Self-checking bench for spell_mem_requester.
// The responder model raises data_ready once select has been held for
// resp_delay registered cycles and drops it together with select;
// resp_delay == 0 models a responder that never answers. force_ready
// holds data_ready high regardless of select.
module tb_spell_mem_requester;
    import spell_mem_pkg::*;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic          req_data_space;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic          mem_select;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in;
    logic          mem_type_data;
    logic          mem_write;
    logic [DW-1:0] mem_data_out;
    logic          mem_data_ready;

    always #5 clk = ~clk;

    spell_mem_requester #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_data_space (req_data_space),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_error      (rsp_error),
        .mem_select     (mem_select),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_type_data  (mem_type_data),
        .mem_write      (mem_write),
        .mem_data_out   (mem_data_out),
        .mem_data_ready (mem_data_ready)
    );

    // ---------------- responder model ----------------
    logic [7:0]  cmem [256];
    logic [7:0]  dmem [256];
    logic [7:0]  sel_cnt = 8'd0;
    int unsigned resp_delay = 1;
    logic        force_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_select)            sel_cnt <= 8'd0;
        else if (sel_cnt != 8'hFF)  sel_cnt <= sel_cnt + 8'd1;
    end

    assign mem_data_ready = force_ready ||
        (mem_select === 1'b1 && resp_delay != 0 && 32'(sel_cnt) >= resp_delay);
    assign mem_data_out   = mem_type_data ? dmem[mem_addr] : cmem[mem_addr];

    always @(posedge clk) begin
        if (mem_select && mem_write && mem_data_ready) begin
            if (mem_type_data) dmem[mem_addr] <= mem_data_in;
            else               cmem[mem_addr] <= mem_data_in;
        end
    end

    // ---------------- select/response monitor ----------------
    logic        mon_clr = 1'b0;
    logic        prev_sel = 1'b0;
    logic [7:0]  first_addr = 8'd0;
    int unsigned sel_cycles = 0;
    int unsigned addr_changes = 0;
    int unsigned rsp_pulses = 0;

    always @(negedge clk) begin
        if (mon_clr) begin
            sel_cycles   <= 0;
            addr_changes <= 0;
            rsp_pulses   <= 0;
            prev_sel     <= 1'b0;
        end else begin
            prev_sel <= mem_select;
            if (mem_select) begin
                sel_cycles <= sel_cycles + 1;
                if (!prev_sel)                    first_addr   <= mem_addr;
                else if (mem_addr !== first_addr) addr_changes <= addr_changes + 1;
            end
            if (rsp_valid) rsp_pulses <= rsp_pulses + 1;
        end
    end

    // ---------------- checking ----------------
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic        sp;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        int unsigned dly;
        logic [7:0]  exp_rdata;
        logic        exp_err;
        int unsigned exp_lat;
    } vec_t;

    vec_t vecs [7];

    // Waits (bounded) for req_ready, then presents the request for one edge.
    task automatic issue(input string tag, input logic wr, input logic sp,
                         input logic [7:0] addr, input logic [7:0] wdata);
        int unsigned w;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        req_write      = wr;
        req_data_space = sp;
        req_addr       = addr;
        req_wdata      = wdata;
        req_valid      = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Cycles from the accepting edge to the edge that raises rsp_valid.
    task automatic wait_rsp(output int unsigned lat, output logic got);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (rsp_valid) got = 1'b1;
        end
    endtask

    task automatic do_access(input string tag, input vec_t v);
        int unsigned lat;
        logic        got;
        resp_delay = v.dly;
        issue(tag, v.wr, v.sp, v.addr, v.wdata);
        check({tag, " select"},  32'(mem_select),    32'd1);
        check({tag, " addr"},    32'(mem_addr),      32'(v.addr));
        check({tag, " space"},   32'(mem_type_data), 32'(v.sp));
        check({tag, " write"},   32'(mem_write),     32'(v.wr));
        check({tag, " data_in"}, 32'(mem_data_in),   32'(v.wdata));
        wait_rsp(lat, got);
        check({tag, " rsp_seen"}, 32'(got), 32'd1);
        check({tag, " latency"},  lat, v.exp_lat);
        check({tag, " rdata"},    32'(rsp_rdata), 32'(v.exp_rdata));
        check({tag, " error"},    32'(rsp_error), 32'(v.exp_err));
        check({tag, " sel_drop"}, 32'(mem_select), 32'd0);
        check({tag, " busy"},     32'(req_ready),  32'd0);
        @(posedge clk);
        #1;
        check({tag, " pulse"},    32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned lat;
        logic        got;
        int unsigned n_acc;
        int unsigned nr;
        int unsigned t [2];
        logic [7:0]  d [2];
        logic        will;

        req_valid = 1'b0; req_write = 1'b0; req_data_space = 1'b0;
        req_addr = '0; req_wdata = '0;
        for (int unsigned i = 0; i < 256; i++) begin
            cmem[i] = 8'h00;
            dmem[i] = 8'h00;
        end
        cmem[8'h10] = 8'hA5;
        cmem[8'h20] = 8'h3C;
        dmem[8'h10] = 8'h66;
        dmem[8'h40] = 8'h99;
        dmem[8'hFE] = 8'h12;
        dmem[8'hFF] = 8'h34;

        vecs[0] = '{wr:1'b0, sp:MEM_SPACE_CODE, addr:8'h10, wdata:8'h00, dly:1, exp_rdata:8'hA5, exp_err:1'b0, exp_lat:2};
        vecs[1] = '{wr:1'b1, sp:MEM_SPACE_DATA, addr:8'h03, wdata:8'h5C, dly:1, exp_rdata:8'h00, exp_err:1'b0, exp_lat:2};
        vecs[2] = '{wr:1'b0, sp:MEM_SPACE_DATA, addr:8'h03, wdata:8'h00, dly:1, exp_rdata:8'h5C, exp_err:1'b0, exp_lat:2};
        vecs[3] = '{wr:1'b0, sp:MEM_SPACE_DATA, addr:8'h40, wdata:8'h00, dly:0, exp_rdata:8'h00, exp_err:1'b1, exp_lat:15};
        vecs[4] = '{wr:1'b1, sp:MEM_SPACE_CODE, addr:8'h7F, wdata:8'h11, dly:2, exp_rdata:8'h00, exp_err:1'b0, exp_lat:3};
        vecs[5] = '{wr:1'b0, sp:MEM_SPACE_CODE, addr:8'h7F, wdata:8'h00, dly:2, exp_rdata:8'h11, exp_err:1'b0, exp_lat:3};
        vecs[6] = '{wr:1'b0, sp:MEM_SPACE_DATA, addr:8'h10, wdata:8'h00, dly:1, exp_rdata:8'h66, exp_err:1'b0, exp_lat:2};

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst req_ready",  32'(req_ready),     32'd0);
        check("rst select",     32'(mem_select),    32'd0);
        check("rst rsp_valid",  32'(rsp_valid),     32'd0);
        check("rst rsp_error",  32'(rsp_error),     32'd0);
        check("rst rsp_rdata",  32'(rsp_rdata),     32'd0);
        check("rst mem_addr",   32'(mem_addr),      32'd0);
        check("rst mem_write",  32'(mem_write),     32'd0);
        check("rst mem_type",   32'(mem_type_data), 32'd0);
        check("rst mem_din",    32'(mem_data_in),   32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("post rst req_ready", 32'(req_ready), 32'd1);

        // Table-driven accesses
        for (int unsigned i = 0; i < 7; i++) begin
            do_access($sformatf("vec%0d", i), vecs[i]);
        end

        // 3-cycle responder: select held 4 cycles, address stable, one pulse
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
        do_access("delay3", '{wr:1'b0, sp:MEM_SPACE_CODE, addr:8'h20, wdata:8'h00,
                              dly:3, exp_rdata:8'h3C, exp_err:1'b0, exp_lat:4});
        repeat (3) @(posedge clk);
        #1;
        check("delay3 sel_cycles",   sel_cycles,   32'd4);
        check("delay3 addr_changes", addr_changes, 32'd0);
        check("delay3 rsp_pulses",   rsp_pulses,   32'd1);

        // Timeout followed by a late data_ready that must be absorbed
        resp_delay = 0;
        issue("late", 1'b0, MEM_SPACE_DATA, 8'h40, 8'h00);
        wait_rsp(lat, got);
        check("late rsp_seen", 32'(got), 32'd1);
        check("late error",    32'(rsp_error), 32'd1);
        check("late latency",  lat, 32'd15);
        force_ready = 1'b1;
        for (int unsigned c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("late no_rsp%0d", c), 32'(rsp_valid), 32'd0);
            check($sformatf("late held%0d", c),   32'(req_ready), 32'd0);
        end
        force_ready = 1'b0;
        @(posedge clk);
        #1;
        check("late ready_back", 32'(req_ready), 32'd1);

        // Reset in the middle of an access with data_ready stuck high
        resp_delay = 0;
        issue("midrst", 1'b0, MEM_SPACE_DATA, 8'h40, 8'h00);
        @(posedge clk);
        #1;
        check("midrst in_access", 32'(mem_select), 32'd1);
        rst = 1'b1;
        force_ready = 1'b1;
        #1;
        check("midrst select",    32'(mem_select), 32'd0);
        check("midrst rsp_valid", 32'(rsp_valid),  32'd0);
        check("midrst mem_addr",  32'(mem_addr),   32'd0);
        check("midrst rsp_rdata", 32'(rsp_rdata),  32'd0);
        check("midrst req_ready", 32'(req_ready),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int unsigned c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("midrst held%0d", c), 32'(req_ready), 32'd0);
        end
        force_ready = 1'b0;
        #1;
        check("midrst ready_back", 32'(req_ready), 32'd1);

        // Back-to-back reads of 0xFE and 0xFF with req_valid held
        resp_delay = 1;
        n_acc = 0;
        nr = 0;
        t[0] = 0; t[1] = 0; d[0] = '0; d[1] = '0;
        for (int unsigned c = 0; c < 30; c++) begin
            @(negedge clk);
            if (n_acc < 2) begin
                req_valid      = 1'b1;
                req_write      = 1'b0;
                req_data_space = MEM_SPACE_DATA;
                req_addr       = (n_acc == 0) ? 8'hFE : 8'hFF;
            end else begin
                req_valid = 1'b0;
            end
            will = req_valid && req_ready;
            @(posedge clk);
            if (will) n_acc++;
            #1;
            if (rsp_valid) begin
                if (nr < 2) begin
                    t[nr] = c;
                    d[nr] = rsp_rdata;
                end
                nr++;
            end
        end
        req_valid = 1'b0;
        check("b2b responses", nr, 32'd2);
        check("b2b first",     32'(d[0]), 32'h12);
        check("b2b second",    32'(d[1]), 32'h34);
        check("b2b spacing",   t[1] - t[0], 32'd4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
